// File: rtl/cache_assoc_controller_pkg.sv
// Shared types and helpers for the set-associative cache controller.
// Holds the controller state encoding and the width helper used for port sizing.
package cache_ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HIT    = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_WRWORD = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_assoc_controller_if.sv
// Request, cache-array and memory-control bundle of the cache controller.
// Signal suffixes are named from the controller's point of view (slave modport).
interface cache_assoc_controller_if #(
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
);
    import cache_ctl_pkg::*;

    localparam int WAY_W = clog2(NUM_WAYS);
    localparam int OFF_W = clog2(WORDS_PER_LINE);

    logic                rd_i;
    logic                wr_i;
    logic [NUM_WAYS-1:0] hit_i;
    logic [NUM_WAYS-1:0] valid_i;
    logic [NUM_WAYS-1:0] dirty_i;
    logic                cache_err_i;
    logic                mem_stall_i;
    logic                mem_err_i;

    logic                comp_o;
    logic                cache_wr_o;
    logic [WAY_W-1:0]    way_sel_o;
    logic [OFF_W-1:0]    cache_off_o;
    logic                mem_rd_o;
    logic                mem_wr_o;
    logic [OFF_W-1:0]    mem_off_o;
    logic                wb_sel_o;
    logic                stall_o;
    logic                done_o;
    logic                cache_hit_o;
    logic                err_o;

    modport slave (
        input  rd_i, wr_i, hit_i, valid_i, dirty_i, cache_err_i, mem_stall_i, mem_err_i,
        output comp_o, cache_wr_o, way_sel_o, cache_off_o, mem_rd_o, mem_wr_o,
               mem_off_o, wb_sel_o, stall_o, done_o, cache_hit_o, err_o
    );

    modport master (
        output rd_i, wr_i, hit_i, valid_i, dirty_i, cache_err_i, mem_stall_i, mem_err_i,
        input  comp_o, cache_wr_o, way_sel_o, cache_off_o, mem_rd_o, mem_wr_o,
               mem_off_o, wb_sel_o, stall_o, done_o, cache_hit_o, err_o
    );

endinterface

// File: rtl/cache_assoc_controller_mem_rd_pipe.sv
// Tracks outstanding refill reads: a DEPTH-stage {valid, offset} shift register
// whose last stage marks the cycle the memory returns that word.
module mem_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [OFF_W-1:0] off_i,
    output logic             head_vld_o,
    output logic [OFF_W-1:0] head_off_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][OFF_W-1:0] off_q;

    // Shift accepted read offsets toward the head; flush drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            off_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            off_q <= '0;
        end else begin
            vld_q[0] <= push_i;
            off_q[0] <= off_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                off_q[i] <= off_q[i-1];
            end
        end
    end

    assign head_vld_o = vld_q[DEPTH-1];
    assign head_off_o = off_q[DEPTH-1];

endmodule

// File: rtl/cache_assoc_controller.sv
// Control FSM for an N-way write-back, write-allocate cache: tag compare,
// victim choice, word-by-word write-back and pipelined refill. Holds no data.
module cache_assoc_controller
    import cache_ctl_pkg::*;
#(
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    cache_assoc_controller_if.slave   bus
);

    localparam int WAY_W = clog2(NUM_WAYS);
    localparam int OFF_W = clog2(WORDS_PER_LINE);
    localparam int CNT_W = WAY_W + 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  ptr_q, ptr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              wr_op_q, wr_op_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  inst_q, inst_d;
    logic              issued_q, issued_d;

    logic [NUM_WAYS-1:0] hv_s;
    logic [CNT_W-1:0]    hit_cnt_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    free_way_s;
    logic [WAY_W-1:0]    victim_sel_s;
    logic                req_s;
    logic                fault_s;
    logic                push_s;
    logic                flush_s;
    logic                head_vld_s;
    logic [OFF_W-1:0]    head_off_s;

    assign hv_s         = bus.hit_i & bus.valid_i;
    assign req_s        = bus.rd_i | bus.wr_i;
    assign fault_s      = bus.cache_err_i | bus.mem_err_i;
    assign victim_sel_s = (&bus.valid_i) ? ptr_q : free_way_s;

    // Count matching ways and locate the lowest hitting and lowest invalid way.
    always_comb begin
        hit_cnt_s  = '0;
        hit_way_s  = '0;
        free_way_s = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            hit_cnt_s  = hit_cnt_s + CNT_W'(hv_s[i]);
            hit_way_s  = hv_s[i] ? WAY_W'(i) : hit_way_s;
            free_way_s = bus.valid_i[i] ? free_way_s : WAY_W'(i);
        end
    end

    mem_rd_pipe #(
        .DEPTH (MEM_LATENCY),
        .OFF_W (OFF_W)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_s),
        .push_i     (push_s),
        .off_i      (cnt_q),
        .head_vld_o (head_vld_s),
        .head_off_o (head_off_s)
    );

    // Next-state, counter and output decode for every controller state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        victim_d = victim_q;
        wr_op_d  = wr_op_q;
        cnt_d    = cnt_q;
        inst_d   = inst_q;
        issued_d = issued_q;
        push_s   = 1'b0;
        flush_s  = 1'b0;

        bus.comp_o      = 1'b0;
        bus.cache_wr_o  = 1'b0;
        bus.way_sel_o   = '0;
        bus.cache_off_o = '0;
        bus.mem_rd_o    = 1'b0;
        bus.mem_wr_o    = 1'b0;
        bus.mem_off_o   = '0;
        bus.wb_sel_o    = 1'b0;
        bus.stall_o     = 1'b0;
        bus.done_o      = 1'b0;
        bus.cache_hit_o = 1'b0;
        bus.err_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.comp_o = 1'b1;
                // Reset asserted while idle must present the plain reset outputs.
                if (rst) begin
                    state_d = S_IDLE;
                end else begin
                    bus.way_sel_o = hit_way_s;
                    if (req_s && ((bus.rd_i && bus.wr_i) || (hit_cnt_s > CNT_W'(1)))) begin
                        ptr_d   = ptr_q + WAY_W'(1);
                        state_d = S_ERR;
                    end else if (req_s && (hit_cnt_s == CNT_W'(1))) begin
                        ptr_d          = ptr_q + WAY_W'(1);
                        bus.cache_wr_o = bus.wr_i;
                        state_d        = S_HIT;
                    end else if (req_s) begin
                        ptr_d    = ptr_q + WAY_W'(1);
                        victim_d = victim_sel_s;
                        wr_op_d  = bus.wr_i;
                        cnt_d    = '0;
                        inst_d   = '0;
                        issued_d = 1'b0;
                        state_d  = (bus.valid_i[victim_sel_s] && bus.dirty_i[victim_sel_s])
                                   ? S_WB : S_FILL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HIT: begin
                bus.done_o      = 1'b1;
                bus.cache_hit_o = 1'b1;
                state_d         = S_IDLE;
            end

            S_WB: begin
                bus.way_sel_o   = victim_q;
                bus.cache_off_o = cnt_q;
                bus.mem_wr_o    = 1'b1;
                bus.mem_off_o   = cnt_q;
                bus.wb_sel_o    = 1'b1;
                bus.stall_o     = 1'b1;
                if (bus.mem_stall_i) begin
                    state_d = S_WB;
                end else if (cnt_q == LAST_OFF) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end else begin
                    cnt_d = cnt_q + OFF_W'(1);
                end
            end

            S_FILL: begin
                bus.stall_o     = 1'b1;
                bus.way_sel_o   = victim_q;
                bus.mem_rd_o    = !issued_q;
                bus.mem_off_o   = issued_q ? '0 : cnt_q;
                bus.cache_wr_o  = head_vld_s;
                bus.cache_off_o = head_vld_s ? head_off_s : '0;
                push_s          = !issued_q && !bus.mem_stall_i;
                // cnt wraps to 0 on the last accepted read; issued_q stops further issue.
                cnt_d    = push_s ? cnt_q + OFF_W'(1) : cnt_q;
                issued_d = issued_q | (push_s && (cnt_q == LAST_OFF));
                inst_d   = head_vld_s ? inst_q + OFF_W'(1) : inst_q;
                if (head_vld_s && (inst_q == LAST_OFF)) begin
                    issued_d = 1'b0;
                    state_d  = wr_op_q ? S_WRWORD : S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end

            S_WRWORD: begin
                bus.comp_o     = 1'b1;
                bus.cache_wr_o = 1'b1;
                bus.way_sel_o  = victim_q;
                bus.stall_o    = 1'b1;
                state_d        = S_DONE;
            end

            S_DONE: begin
                bus.done_o = 1'b1;
                state_d    = S_IDLE;
            end

            S_ERR: begin
                bus.done_o = 1'b1;
                bus.err_o  = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An array or memory error aborts any busy state and drops pending refills.
        if (fault_s && (state_q != S_IDLE) && (state_q != S_ERR)) begin
            state_d  = S_ERR;
            flush_s  = 1'b1;
            push_s   = 1'b0;
            cnt_d    = '0;
            inst_d   = '0;
            issued_d = 1'b0;
        end else begin
            flush_s = flush_s;
        end
    end

    // State, victim and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            victim_q <= '0;
            wr_op_q  <= 1'b0;
            cnt_q    <= '0;
            inst_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            victim_q <= victim_d;
            wr_op_q  <= wr_op_d;
            cnt_q    <= cnt_d;
            inst_q   <= inst_d;
            issued_q <= issued_d;
        end
    end

endmodule

// File: doc/cache_assoc_controller.md
Name: cache_assoc_controller

Overview:
- Control FSM for an N-way set-associative, write-back, write-allocate cache in front of a banked, fixed-latency main memory.
- Per request: does the tag compare, picks a victim way, writes back a dirty line word by word, refills the line with pipelined reads, then completes.
- Sits between the CPU memory stage (rd/wr, done, stall) and the cache data/tag arrays plus the memory datapath; it holds no data itself.

Parameters:
- NUM_WAYS, 2, number of ways (power of 2, ≥2).
- WORDS_PER_LINE, 4, words per line; equals the number of memory transfers per line (power of 2).
- MEM_LATENCY, 2, cycles from mem_rd issue to read data valid (≥1).
- Derived: WAY_W=clog2(NUM_WAYS), OFF_W=clog2(WORDS_PER_LINE).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd  in  1  read request
- wr  in  1  write request
- hit  in  NUM_WAYS  per-way tag match
- valid  in  NUM_WAYS  per-way valid bit of indexed set
- dirty  in  NUM_WAYS  per-way dirty bit of indexed set
- cache_err  in  1  cache array error
- mem_stall  in  1  memory bank busy; current issue not accepted
- mem_err  in  1  memory error
- comp  out  1  compare mode to cache arrays
- cache_wr  out  1  cache array write enable
- way_sel  out  WAY_W  way driven to arrays
- cache_off  out  OFF_W  word offset for array access when comp=0
- mem_rd  out  1  memory read issue
- mem_wr  out  1  memory write issue
- mem_off  out  OFF_W  word offset of memory transfer
- wb_sel  out  1  1 = memory address uses victim tag, 0 = request tag
- stall  out  1  pipeline stall
- done  out  1  request complete (one cycle)
- cache_hit  out  1  completed request was a hit (with done)
- err  out  1  error (with done)

Behaviour:
- Reset: state=IDLE, victim pointer=0, in-flight pipe cleared. All outputs 0 except comp=1 (IDLE lookup). Reset mid-operation abandons the transaction; no done is issued.
- Victim pointer: WAY_W-bit counter, increments on every accepted request.
- Victim select: lowest-index invalid way; if all ways are valid, use the victim pointer value.
- IDLE:
  - comp=1; way_sel=hitting way.
  - If rd^wr and exactly one way has hit&valid: cache_wr=wr this cycle; go to HIT.
  - If rd&wr, or more than one way has hit&valid: go to ERR.
  - Else if rd|wr (miss): latch victim. Victim valid&dirty → WB; otherwise → FILL.
  - Neither rd nor wr: stay in IDLE.
- HIT: done=1, cache_hit=1 → IDLE. Hit latency is 1 cycle after the request.
- WB:
  - Each cycle: comp=0, way_sel=victim, cache_off=cnt, mem_wr=1, mem_off=cnt, wb_sel=1, stall=1.
  - mem_stall=1 holds cnt and re-issues next cycle.
  - After WORDS_PER_LINE accepted writes → FILL.
- FILL:
  - Issue phase: mem_rd=1, mem_off=cnt, wb_sel=0, until WORDS_PER_LINE reads are accepted; mem_stall behaves as in WB.
  - Each accepted read pushes its offset into a MEM_LATENCY-deep valid/offset pipe.
  - Any cycle the pipe head is valid: cache_wr=1, comp=0, way_sel=victim, cache_off=head offset.
  - stall=1 throughout.
  - Leave after the final install: rd → DONE; wr → WRWORD.
- WRWORD: comp=1, cache_wr=1, way_sel=victim (datapath supplies request offset and data), stall=1 → DONE.
- DONE: done=1, cache_hit=0 → IDLE.
- ERR: done=1, err=1 → IDLE. cache_err or mem_err in any non-IDLE state jumps to ERR next cycle; the in-flight pipe is flushed.
- rd/wr are sampled only in IDLE. Changes during stall are ignored, and the datapath holds the address.
- Counters wrap to 0 on exit. cnt never exceeds WORDS_PER_LINE-1.

Decomposition:
- Package cache_ctl_pkg: state encoding constants (IDLE, HIT, WB, FILL, WRWORD, DONE, ERR) and the clog2 function.
- One sub-module: mem_rd_pipe. It is a MEM_LATENCY-stage shift register of {valid, offset}, with a flush input, and exposes the head.

Test Plan:
- Defaults. Read hit in way 1 (hit=2'b10, valid=2'b10) at t0 → t0: way_sel=1, comp=1; t1: done=1, cache_hit=1; victim pointer=1.
- Clean read miss, valid=2'b01 → victim way 1. mem_rd at t1–t4 with mem_off 0..3. cache_wr at t3–t6 with cache_off 0..3. done at t7, cache_hit=0.
- Dirty write miss, valid=dirty=2'b11, pointer=0 → mem_wr with wb_sel=1 at t1–t4. mem_rd at t5–t8. Installs at t7–t10. WRWORD at t11 (comp=1, cache_wr=1). done at t12.
- mem_stall high at t2 during WB → mem_off stays 1 in t2 and t3, mem_wr stays high. Total latency grows by exactly 1.
- rd=wr=1 at t0 → t1: done=1, err=1. Separately, mem_err at t5 of a fill → ERR at t6, no further cache_wr.
- rst asserted mid-FILL → all outputs return to reset values immediately. The next request is handled normally from IDLE.
